// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART transmit/receive framers.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int MAX_DATA_BITS = 9;

  function automatic int tics_per_beat(input int freq, input int baud);
    if (baud <= 0) begin
      return 0;
    end else begin
      return freq / baud;
    end
  endfunction

  // Simulation builds run at a much faster line rate so frames stay short.
  function automatic int used_baud_rate(input int baud, input int baud_sim, input bit sim_build);
    if (sim_build) begin
      return baud_sim;
    end else begin
      return baud;
    end
  endfunction

  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input parity_t par);
    case (par)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~(^data);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: restart reloads it, bit_end pulses on the last tic of each bit.
module uart_baud_tick #(
  parameter int TICS_PER_BEAT = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (TICS_PER_BEAT > 2) ? $clog2(TICS_PER_BEAT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICS_PER_BEAT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             bit_end_r;

  // bit_end_r is high exactly while cnt_r == 0, kept as a flop for a clean pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_r     <= RELOAD;
      bit_end_r <= 1'b0;
    end else if (restart) begin
      cnt_r     <= RELOAD;
      bit_end_r <= 1'b0;
    end else if (cnt_r == {CNT_W{1'b0}}) begin
      cnt_r     <= RELOAD;
      bit_end_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_r - CNT_W'(1);
      bit_end_r <= (cnt_r == CNT_W'(1));
    end
  end

  assign bit_end = bit_end_r;

endmodule

// File: rtl/uart_tx_frame.sv
// AXI-Stream to UART transmitter: one beat per frame, one-entry hold for back-to-back frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int BAUD_RATE_SIM  = 50000000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  output logic                 uart_txd,
  input  logic                 txdata_tvalid,
  output logic                 txdata_tready,
  input  logic [DATA_BITS-1:0] txdata_tdata,
  input  logic                 txdata_tkeep,
  output logic                 tx_busy
);

`ifdef SYNTHESIS
  localparam bit SIM_BUILD = 1'b0;
`else
  localparam bit SIM_BUILD = 1'b1;
`endif

  localparam int USED_BAUD_RATE = used_baud_rate(BAUD_RATE, BAUD_RATE_SIM, SIM_BUILD);
  localparam int TICS_PER_BEAT  = tics_per_beat(ACLK_FREQUENCY, USED_BAUD_RATE);
  localparam int BIT_CNT_W      = $clog2(DATA_BITS + 1);
  localparam parity_t PAR_CFG   = parity_t'(PARITY[1:0]);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  if (TICS_PER_BEAT < 2) begin : g_bad_tics
    $error("uart_tx_frame: TICS_PER_BEAT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be within 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  tx_state_t              state_r, state_n;
  logic [DATA_BITS-1:0]   shift_r, shift_n;
  logic [DATA_BITS-1:0]   hold_data_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_n;
  logic                   par_r;
  logic                   hold_full_r, hold_full_n;
  logic                   tready_r;
  logic                   busy_r;
  logic                   txd_r, txd_n;
  logic                   load_s;
  logic                   accept_s;
  logic                   bit_end_s;

  uart_baud_tick #(
    .TICS_PER_BEAT(TICS_PER_BEAT)
  ) u_baud_tick (
    .aclk   (aclk),
    .areset (areset),
    .restart(load_s),
    .bit_end(bit_end_s)
  );

  assign accept_s = txdata_tvalid && tready_r;

  // Hold occupancy: a kept beat fills it, a shifter load drains it; fill wins on a tie.
  always_comb begin
    hold_full_n = hold_full_r;
    if (accept_s && txdata_tkeep) begin
      hold_full_n = 1'b1;
    end else if (load_s) begin
      hold_full_n = 1'b0;
    end else begin
      hold_full_n = hold_full_r;
    end
  end

  // Frame sequencing; txd_n is the line level for the bit that starts at the next edge.
  always_comb begin
    state_n   = state_r;
    shift_n   = shift_r;
    bit_cnt_n = bit_cnt_r;
    txd_n     = txd_r;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          load_s  = 1'b1;
          state_n = ST_START;
          txd_n   = 1'b0;
        end else begin
          state_n = ST_IDLE;
          txd_n   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_n   = ST_DATA;
          bit_cnt_n = {BIT_CNT_W{1'b0}};
          txd_n     = shift_r[0];
        end else begin
          txd_n = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_DATA) begin
            bit_cnt_n = {BIT_CNT_W{1'b0}};
            if (PAR_CFG != PAR_NONE) begin
              state_n = ST_PARITY;
              txd_n   = par_r;
            end else begin
              state_n = ST_STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt_r + BIT_CNT_W'(1);
            shift_n   = shift_r >> 1;
            txd_n     = shift_r[1];
          end
        end else begin
          txd_n = shift_r[0];
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_n   = ST_STOP;
          bit_cnt_n = {BIT_CNT_W{1'b0}};
          txd_n     = 1'b1;
        end else begin
          txd_n = par_r;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_STOP) begin
            if (hold_full_r) begin
              load_s  = 1'b1;
              state_n = ST_START;
              txd_n   = 1'b0;
            end else begin
              state_n = ST_IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt_r + BIT_CNT_W'(1);
            txd_n     = 1'b1;
          end
        end else begin
          txd_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath, hold register and registered stream/line outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shift_r     <= {DATA_BITS{1'b0}};
      hold_data_r <= {DATA_BITS{1'b0}};
      bit_cnt_r   <= {BIT_CNT_W{1'b0}};
      par_r       <= 1'b0;
      hold_full_r <= 1'b0;
      tready_r    <= 1'b0;
      busy_r      <= 1'b0;
      txd_r       <= 1'b1;
    end else begin
      hold_full_r <= hold_full_n;
      tready_r    <= !hold_full_n;
      busy_r      <= (state_n != ST_IDLE) || hold_full_n;
      txd_r       <= txd_n;
      if (accept_s && txdata_tkeep) begin
        hold_data_r <= txdata_tdata;
      end
      if (load_s) begin
        shift_r   <= hold_data_r;
        bit_cnt_r <= {BIT_CNT_W{1'b0}};
        par_r     <= parity_bit(MAX_DATA_BITS'(hold_data_r), PAR_CFG);
      end else begin
        shift_r   <= shift_n;
        bit_cnt_r <= bit_cnt_n;
      end
    end
  end

  assign uart_txd      = txd_r;
  assign txdata_tready = tready_r;
  assign tx_busy       = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances (8N1, 7E2, 8O1, 9N1) at 4 aclk cycles per bit.
module tb_uart_tx_frame;

  logic       aclk = 1'b0;
  logic       areset;
  logic       txd_s    [4];
  logic       tready_s [4];
  logic       busy_s   [4];
  logic       tvalid_s [4];
  logic       tkeep_s  [4];
  logic [7:0] tdata0;
  logic [6:0] tdata1;
  logic [7:0] tdata2;
  logic [8:0] tdata3;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE(25000000), .BAUD_RATE_SIM(25000000),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .aclk(aclk), .areset(areset), .uart_txd(txd_s[0]), .txdata_tvalid(tvalid_s[0]),
    .txdata_tready(tready_s[0]), .txdata_tdata(tdata0), .txdata_tkeep(tkeep_s[0]), .tx_busy(busy_s[0]));

  uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE(25000000), .BAUD_RATE_SIM(25000000),
                  .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7e2 (
    .aclk(aclk), .areset(areset), .uart_txd(txd_s[1]), .txdata_tvalid(tvalid_s[1]),
    .txdata_tready(tready_s[1]), .txdata_tdata(tdata1), .txdata_tkeep(tkeep_s[1]), .tx_busy(busy_s[1]));

  uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE(25000000), .BAUD_RATE_SIM(25000000),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .aclk(aclk), .areset(areset), .uart_txd(txd_s[2]), .txdata_tvalid(tvalid_s[2]),
    .txdata_tready(tready_s[2]), .txdata_tdata(tdata2), .txdata_tkeep(tkeep_s[2]), .tx_busy(busy_s[2]));

  uart_tx_frame #(.ACLK_FREQUENCY(100000000), .BAUD_RATE(25000000), .BAUD_RATE_SIM(25000000),
                  .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .aclk(aclk), .areset(areset), .uart_txd(txd_s[3]), .txdata_tvalid(tvalid_s[3]),
    .txdata_tready(tready_s[3]), .txdata_tdata(tdata3), .txdata_tkeep(tkeep_s[3]), .tx_busy(busy_s[3]));

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each line bit becomes four per-cycle samples; bit 0 of 'bits' goes on the line first.
  function automatic logic [127:0] expand(input logic [31:0] bits, input int nbits);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < nbits; i++) begin
      for (int k = 0; k < 4; k++) begin
        v[i*4 + k] = bits[i];
      end
    end
    return v;
  endfunction

  task automatic send(input int idx, input logic [8:0] data, input logic keep, output int edges);
    logic acc;
    acc   = 1'b0;
    edges = 0;
    case (idx)
      0: tdata0 = data[7:0];
      1: tdata1 = data[6:0];
      2: tdata2 = data[7:0];
      default: tdata3 = data[8:0];
    endcase
    tkeep_s[idx]  = keep;
    tvalid_s[idx] = 1'b1;
    while (!acc && edges < 200) begin
      acc = tready_s[idx];
      step();
      edges++;
    end
    tvalid_s[idx] = 1'b0;
    check("send_accepted", 128'(acc), 128'(1'b1));
  endtask

  task automatic capture(input int idx, input int n, output logic [127:0] v);
    int waited;
    waited = 0;
    v = '0;
    while (txd_s[idx] !== 1'b0 && waited < 40) begin
      step();
      waited++;
    end
    check("start_seen", 128'(txd_s[idx]), 128'(1'b0));
    for (int j = 0; j < n; j++) begin
      v[j] = txd_s[idx];
      if (j < n - 1) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] cap;
    int e0, e1, e2;
    logic idle_ok;

    areset = 1'b1;
    tdata0 = '0; tdata1 = '0; tdata2 = '0; tdata3 = '0;
    for (int i = 0; i < 4; i++) begin
      tvalid_s[i] = 1'b0;
      tkeep_s[i]  = 1'b1;
    end
    repeat (3) step();
    check("reset_txd",    128'({txd_s[0], txd_s[1], txd_s[2], txd_s[3]}), 128'(4'b1111));
    check("reset_tready", 128'({tready_s[0], tready_s[1], tready_s[2], tready_s[3]}), 128'(4'b0000));
    check("reset_busy",   128'({busy_s[0], busy_s[1], busy_s[2], busy_s[3]}), 128'(4'b0000));
    areset = 1'b0;
    step();
    check("tready_after_release", 128'({tready_s[0], tready_s[1], tready_s[2], tready_s[3]}), 128'(4'b1111));

    // 8N1 0xA5: start bit one edge after the accepting edge.
    tdata0 = 8'hA5; tkeep_s[0] = 1'b1; tvalid_s[0] = 1'b1;
    step();
    tvalid_s[0] = 1'b0;
    check("8n1_tready_hold_full", 128'(tready_s[0]), 128'(1'b0));
    check("8n1_busy_hold_full",   128'(busy_s[0]),   128'(1'b1));
    step();
    check("8n1_start_latency",    128'(txd_s[0]),    128'(1'b0));
    check("8n1_tready_after_load", 128'(tready_s[0]), 128'(1'b1));
    capture(0, 40, cap);
    check("8n1_frame_a5", cap, expand({1'b1, 8'hA5, 1'b0}, 10));
    step();
    check("8n1_busy_end", 128'(busy_s[0]), 128'(1'b0));
    check("8n1_idle_high", 128'(txd_s[0]), 128'(1'b1));

    // Null beat is consumed in one edge and produces nothing; only 0x0F follows.
    send(0, 9'h055, 1'b0, e0);
    check("null_edges",  128'(e0),          128'(1));
    check("null_tready", 128'(tready_s[0]), 128'(1'b1));
    check("null_busy",   128'(busy_s[0]),   128'(1'b0));
    check("null_line",   128'(txd_s[0]),    128'(1'b1));
    fork
      capture(0, 40, cap);
      send(0, 9'h00F, 1'b1, e1);
    join
    check("null_then_0f", cap, expand({1'b1, 8'h0F, 1'b0}, 10));
    step();

    // 7E2 0x35: four ones, even parity bit 0, two stop bits, 44 cycles.
    fork
      capture(1, 44, cap);
      send(1, 9'h035, 1'b1, e0);
    join
    check("7e2_frame_35", cap, expand({2'b11, 1'b0, 7'h35, 1'b0}, 11));
    step();
    check("7e2_busy_end", 128'(busy_s[1]), 128'(1'b0));

    // 8O1 0x00 then 0xFF with tvalid held: back-to-back, both parity bits 1.
    fork
      capture(2, 88, cap);
      begin
        send(2, 9'h000, 1'b1, e0);
        send(2, 9'h0FF, 1'b1, e1);
      end
    join
    check("8o1_back_to_back", cap,
          expand({1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 22));
    step();
    check("8o1_busy_after_stop", 128'(busy_s[2]), 128'(1'b0));
    check("8o1_line_idle",       128'(txd_s[2]),  128'(1'b1));

    // 9N1 0x1AB then 0x0F5 with random tvalid gaps: one frame per 44 cycles.
    repeat ($urandom_range(0, 3)) step();
    fork
      capture(3, 88, cap);
      begin
        send(3, 9'h1AB, 1'b1, e0);
        repeat ($urandom_range(1, 8)) step();
        send(3, 9'h0F5, 1'b1, e2);
      end
    join
    check("9n1_two_frames", cap,
          expand({1'b1, 9'h0F5, 1'b0, 1'b1, 9'h1AB, 1'b0}, 22));
    step();
    check("9n1_busy_end", 128'(busy_s[3]), 128'(1'b0));

    // Reset in the DATA phase of 0x81 with 0x7E held.
    send(0, 9'h081, 1'b1, e0);
    step();
    send(0, 9'h07E, 1'b1, e1);
    check("rst_hold_full_tready", 128'(tready_s[0]), 128'(1'b0));
    repeat (8) step();
    check("rst_mid_data_low", 128'(txd_s[0]), 128'(1'b0));
    areset = 1'b1;
    #1;
    check("rst_txd_immediate",    128'(txd_s[0]),    128'(1'b1));
    check("rst_tready_immediate", 128'(tready_s[0]), 128'(1'b0));
    check("rst_busy_immediate",   128'(busy_s[0]),   128'(1'b0));
    step();
    step();
    areset = 1'b0;
    step();
    check("rst_tready_release", 128'(tready_s[0]), 128'(1'b1));
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (txd_s[0] !== 1'b1 || busy_s[0] !== 1'b0) idle_ok = 1'b0;
      step();
    end
    check("rst_no_residual_frame", 128'(idle_ok), 128'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
